// File: rtl/mux_nto1_stream.sv
// Registered N:1 streaming multiplexer with valid/ready handshakes.
// Channel choice is either an external select or round-robin arbitration.
module mux_nto1_stream #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] chan_q, chan_d;
    logic            valid_q, valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load;
    logic            xfer;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [W-1:0]    gnt_data;
    logic            hi_found, lo_found;
    logic [SELW-1:0] hi_idx, lo_idx;

    assign load = !valid_q || out_ready;

    // Descending scans leave the lowest matching index as the winner.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    if (SELW'(i) >= ptr_q) begin
                        hi_found = 1'b1;
                        hi_idx   = SELW'(i);
                    end else begin
                        lo_found = 1'b1;
                        lo_idx   = SELW'(i);
                    end
                end
            end
            gnt_vld = hi_found || lo_found;
            gnt_idx = hi_found ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data    = in_data[i*W +: W];
                in_ready[i] = load && rst_n && gnt_vld;
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = gnt_data;
            chan_d  = gnt_idx;
            valid_d = 1'b1;
            if (mode) begin
                ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule
